// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// controller state encoding and the default iteration count.
package rv32m_pkg;

  localparam int DATA_W       = 32;
  localparam int ITER_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One 33-bit add/subtract step, shared by the shift-add multiply and the
// restoring divide iterations.
//   a, b : 33-bit operands
//   sub  : 1 selects a - b, 0 selects a + b
//   sum  : 33-bit result
//   cout : carry out; for subtraction 1 means a >= b (no borrow)
module muldiv_step (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);

  logic [33:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
  end

  assign sum  = full[32:0];
  assign cout = full[33];

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   valid   : operation request, taken when ready is high
//   funct3  : op code (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   da, db  : rs1 / rs2 operands
//   flush   : aborts the operation in flight, blocks accept in IDLE
//   ready   : high only in IDLE
//   done    : one-cycle pulse when result is valid
//   result  : result, held until the next accept
module rv32m_muldiv
  import rv32m_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] da,
  input  logic [31:0] db,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);

  localparam int CW = $clog2(ITER + 1);

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  state_t state, state_d;

  logic [CW-1:0] cnt;
  logic [2:0]    op;
  logic          is_div;
  logic          neg_a, neg_b;
  logic [32:0]   hi;     // multiply: upper product; divide: partial remainder
  logic [31:0]   lo;     // multiply: multiplier/lower product; divide: dividend/quotient
  logic [31:0]   opnd;   // multiply: multiplicand magnitude; divide: divisor magnitude

  // ---- accept: operand decode ----
  logic               accept;
  logic               a_sgn, b_sgn, na, nb;
  logic signed [31:0] sa, sb;
  logic [31:0]        mag_a, mag_b;
  logic               div_zero, div_ovf, special;
  logic [31:0]        special_res;

  assign sa     = da;
  assign sb     = db;
  assign accept = (state == ST_IDLE) && valid && !flush;

  always_comb begin
    if (funct3[2]) begin
      a_sgn = !funct3[0];
      b_sgn = !funct3[0];
    end else begin
      a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
      b_sgn = (funct3 == F3_MULH);
    end
    na    = a_sgn && (sa < 0);
    nb    = b_sgn && (sb < 0);
    mag_a = na ? neg32(da) : da;
    mag_b = nb ? neg32(db) : db;

    div_zero = funct3[2] && (db == 32'd0);
    div_ovf  = funct3[2] && !funct3[0] && (da == 32'h8000_0000) && (db == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = funct3[1] ? da : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // ---- controller ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC:  if (cnt == CW'(ITER - 1)) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // ---- iteration step ----
  logic [32:0] shifted, step_a, step_sum, mul_s;
  logic        step_cout;

  assign shifted = {hi[31:0], lo[31]};
  assign step_a  = is_div ? shifted : hi;

  muldiv_step u_step (
    .a    (step_a),
    .b    ({1'b0, opnd}),
    .sub  (is_div),
    .sum  (step_sum),
    .cout (step_cout)
  );

  assign mul_s = lo[0] ? step_sum : hi;

  // ---- fixup: sign correction and result select ----
  logic [63:0] prod, prod_f;
  logic [31:0] quo_f, rem_f, fix_res;

  always_comb begin
    prod   = {hi[31:0], lo};
    prod_f = (neg_a ^ neg_b) ? neg64(prod) : prod;
    quo_f  = (neg_a ^ neg_b) ? neg32(lo) : lo;
    rem_f  = neg_a ? neg32(hi[31:0]) : hi[31:0];
    case (op)
      F3_MUL:                      fix_res = prod_f[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_f[63:32];
      F3_DIV, F3_DIVU:             fix_res = quo_f;
      default:                     fix_res = rem_f;
    endcase
  end

  // ---- registered datapath and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= 32'd0;
      cnt    <= '0;
      op     <= 3'd0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      hi     <= 33'd0;
      lo     <= 32'd0;
      opnd   <= 32'd0;
    end else begin
      ready <= (state_d == ST_IDLE);
      done  <= (state_d == ST_DONE);
      if (accept) begin
        op     <= funct3;
        is_div <= funct3[2];
        neg_a  <= na;
        neg_b  <= nb;
        cnt    <= '0;
        hi     <= 33'd0;
        if (funct3[2]) begin
          lo   <= mag_a;
          opnd <= mag_b;
        end else begin
          lo   <= mag_b;
          opnd <= mag_a;
        end
        if (special) result <= special_res;
      end else if (state == ST_CALC && !flush) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          hi <= step_cout ? step_sum : shifted;
          lo <= {lo[30:0], step_cout};
        end else begin
          hi <= {1'b0, mul_s[32:1]};
          lo <= {mul_s[0], lo[31:1]};
        end
      end else if (state == ST_FIXUP && !flush) begin
        result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv.sv
module tb_rv32m_muldiv;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] da = 32'd0;
  logic [31:0] db = 32'd0;
  logic        ready, done;
  logic [31:0] result;

  rv32m_muldiv #(.ITER(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid),
    .funct3 (funct3),
    .da     (da),
    .db     (db),
    .flush  (flush),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } txn_t;

  txn_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  logic prev_done = 1'b0;
  txn_t mon_t;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_single_pulse", {31'd0, prev_done}, 32'd0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: done=1 with result 0x%08h, required no done", result);
      end else begin
        mon_t = sbq.pop_front();
        check({mon_t.name, "_result"}, result, mon_t.exp);
        check({mon_t.name, "_latency"}, 32'(cyc - mon_t.acc + 1), 32'(mon_t.lat));
      end
    end
    prev_done = done;
  end

  // Issue one op from a negedge; returns at the following negedge.
  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit push);
    int   w;
    txn_t t;
    w = 0;
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready_timeout: ready=%b, required 1", nm, ready);
      return;
    end
    funct3 = f;
    da     = a;
    db     = b;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (push) begin
      t.name = nm;
      t.exp  = exp;
      t.lat  = lat;
      t.acc  = cyc;
      sbq.push_back(t);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    #12;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    issue("mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 1'b1);
    issue("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1);
    issue("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b1);
    issue("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b1);
    issue("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 1'b1);
    issue("divu",   F3_DIVU,   32'd100,        32'd7,         32'd14,        34, 1'b1);
    issue("remu",   F3_REMU,   32'd100,        32'd7,         32'd2,         34, 1'b1);
    issue("div_ovf", F3_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    issue("rem_ovf", F3_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1'b1);
    issue("rem_dz",  F3_REM,   32'd5,          32'd0,         32'd5,         1, 1'b1);
    issue("div_dz",  F3_DIV,   32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1'b1);
    drain();

    // flush ten edges into CALC; the flushed op must never complete
    issue("flushed", F3_MUL, 32'd9, 32'd9, 32'd0, 0, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, 32'hFFFF_FFFF);
    issue("mulhu_after_flush", F3_MULHU, 32'd3, 32'd5, 32'd0, 34, 1'b1);
    drain();

    // asynchronous reset in the middle of CALC
    issue("reset_victim", F3_DIV, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", {31'd0, ready}, 32'd1);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    issue("divu_after_reset", F3_DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b1);
    if (sbq.size() != 0) check("accept_first_edge", 32'(sbq[$].acc), 32'(rel + 1));
    else check("accept_first_edge", 32'd0, 32'(rel + 1));
    drain();
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv.md
RV32M_MULDIV -- requirements
Module: rv32m_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: valid  in  1  operation request.
REQ-004 SHALL have: funct3  in  3  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have: da, db  in  32 each  rs1/rs2 operands.
REQ-006 SHALL have: flush  in  1  pipeline kill, aborts the current operation.
REQ-007 SHALL have: ready  out  1  high only in IDLE.
REQ-008 SHALL have: done  out  1  one-cycle pulse, result valid.
REQ-009 SHALL have: result  out  32  result, held until the next accept.
REQ-010 SHALL have parameter ITER, default 32, meaning iteration count (one bit per cycle).

Function
REQ-011 SHALL accept an operation on a rising edge with valid=1 and ready=1, latching funct3, da and db.
REQ-012 SHALL ignore valid when ready=0.
REQ-013 SHALL implement states IDLE, CALC, FIXUP and DONE.
REQ-014 SHALL make these transitions: IDLE->CALC on accept; CALC->FIXUP after ITER edges; FIXUP->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL assert done only in DONE, giving normal latency of 34 edges from the accept edge to done high (ITER=32).
REQ-016 SHALL perform multiply as radix-2 shift-add on 32-bit magnitudes into a 64-bit product.
- Operand signedness: MULH both signed; MULHSU da signed, db unsigned; MULHU and MUL unsigned magnitudes.
- FIXUP negates the product when the operand signs differ.
REQ-017 SHALL return product[31:0] for MUL and product[63:32] for MULH, MULHSU and MULHU.
REQ-018 SHALL perform divide as radix-2 restoring division on magnitudes (signed for DIV/REM, raw for DIVU/REMU).
- FIXUP negates the quotient if the signs differ.
- FIXUP negates the remainder if the dividend is negative.
REQ-019 SHALL handle divide-by-zero (db=0) by going IDLE->DONE directly, with done high after 1 edge.
- Results: DIV/DIVU 0xFFFFFFFF; REM/REMU da.
REQ-020 SHALL handle signed overflow (DIV/REM with da=0x80000000 and db=0xFFFFFFFF) by going IDLE->DONE directly.
- Results: DIV 0x80000000; REM 0.
REQ-021 SHALL treat flush=1 in CALC, FIXUP or DONE as follows: next state IDLE, done=0, result unchanged.
REQ-022 SHALL give flush priority over both done and accept; flush=1 in IDLE blocks accept that cycle.
REQ-023 SHALL load result only in FIXUP or on the special-case edge.

Reset
REQ-024 SHALL, on rst_n low at any time, force state IDLE, ready=1, done=0, result=0, and clear all internal registers.
REQ-025 SHALL, when reset is asserted mid-operation, discard the operation with no done pulse after release.
REQ-026 SHALL accept valid on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place funct3 op constants, the state enum and ITER default in shared package rv32m_pkg.
REQ-028 SHALL use exactly one sub-module, muldiv_step: a combinational 33-bit add/subtract step shared by the multiply and divide iterations.
REQ-029 SHALL register all outputs, with no combinational path from inputs to done or result.

Verification
REQ-030 SHALL cover: MUL da=7, db=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 edges after accept, single-cycle pulse.
REQ-031 SHALL cover high-word multiplies:
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 SHALL cover divides:
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
- REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14.
- REMU 100/7 -> 2.
REQ-033 SHALL cover special cases, each with done 1 edge after accept:
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-034 SHALL cover flush 10 edges into CALC:
- No done; ready high next cycle; result unchanged.
- Immediately following MULHU 3*5 -> 0, done at 34 edges.
REQ-035 SHALL cover rst_n pulsed low mid-CALC: outputs go to reset values asynchronously, no done afterwards, and valid is accepted on the first edge after release.
